instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Initiator side of the instruction-memory read interface.
- Owns the program counter and drives PCAddress to InstructionMemory, which returns Instruction combinationally in the same cycle.
- Latches each fetched word into an IF/ID pipeline register with valid, stall, branch-redirect and halt handling.
- Sits between InstructionMemory and the decode stage of the 16-bit CPU.

Parameters:
ADDR_W, 16, width of PCAddress / PC register
INSTR_W, 16, width of Instruction and IF/ID instruction register
RESET_PC, 16'h0000, PC value loaded on reset
PC_STEP, 2, PC increment per fetched instruction (byte addressing, 16-bit words)
HALT_OPCODE, 16'hFFFF, instruction word that stops fetching

Ports:
Clk  input  1  system clock, all state updates on rising edge
Reset  input  1  synchronous, active-high reset
Start  input  1  leave IDLE and begin fetching (sampled in IDLE only)
Stall  input  1  decode stage backpressure; hold PC and IF/ID registers
BranchTaken  input  1  redirect request from execute stage
BranchTarget  input  ADDR_W  redirect address
PCAddress  output  ADDR_W  address to InstructionMemory; equals PC register
Instruction  input  INSTR_W  word returned by InstructionMemory for PCAddress
IFID_Instr  output  INSTR_W  latched instruction to decode
IFID_PC  output  ADDR_W  address of IFID_Instr
IFID_Valid  output  1  IFID_Instr holds a real instruction
Halted  output  1  fetch stopped on HALT_OPCODE
FetchCount  output  16  fetched-instruction counter (see Optional Feature)

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high; it is sampled on the Clk rising edge.
- Reset has top priority. On reset:
  - PC=RESET_PC, so PCAddress=RESET_PC.
  - IFID_Instr=0, IFID_PC=0, IFID_Valid=0.
  - Halted=0, FetchCount=0.
  - State=IDLE.
- Reset asserted in any state, mid-stall or mid-branch, produces exactly the reset values above on the next edge.
- States: IDLE, RUN, HALT.
- IDLE:
  - PC holds and IF/ID registers hold reset values.
  - Stall and BranchTaken are ignored.
  - Start=1 moves to RUN; the first capture happens on the next edge after entering RUN.
- RUN: each edge resolves in the priority order below, highest first.
  1. BranchTaken=1:
     - PC <= {BranchTarget[ADDR_W-1:1],1'b0} (forced even).
     - IF/ID flushed: IFID_Valid<=0, IFID_Instr<=0, IFID_PC<=0.
     - No count.
     - BranchTaken wins over a simultaneous Stall.
  2. Stall=1:
     - PC, IFID_* and FetchCount all hold.
  3. Normal fetch:
     - IFID_Instr<=Instruction, IFID_PC<=PC, IFID_Valid<=1.
     - FetchCount increments.
     - If Instruction==HALT_OPCODE: PC holds and the next state is HALT; the halt word itself is delivered valid.
     - Otherwise PC <= PC+PC_STEP, modulo 2^ADDR_W (0xFFFE+2 -> 0x0000, no flag).
- HALT:
  - Halted=1.
  - IFID_Valid<=0 on the first edge in HALT, and stays 0.
  - PC holds; IFID_Instr and IFID_PC hold their last values.
  - Start, Stall and BranchTaken are ignored; only Reset exits.
- Latency:
  - Instruction at PC appears on IFID_Instr one edge after PCAddress=PC with Stall=0.
  - Branch redirect: PCAddress=target one edge after BranchTaken; the first valid target instruction follows one edge later.
- PCAddress is a register output, glitch-free and stable for the whole cycle.
- Instruction is treated as combinational from PCAddress; no memory handshake.

Optional Feature:
- Macro: FETCH_COUNT_EN.
- Defined: FetchCount is a 16-bit register.
  - Reset to 0.
  - Increments on each normal fetch (including the halt word).
  - Holds on stall, branch, IDLE and HALT.
  - Wraps 0xFFFF -> 0x0000.
- Undefined: no counter logic; FetchCount is tied to 16'h0000. Port list is unchanged.

Test Plan:
- Reset then idle: Reset=1 for 2 edges, Start=0 for 5 edges -> PCAddress=0x0000, IFID_Valid=0, Halted=0, FetchCount=0 throughout.
- Sequential fetch: RESET_PC=10, memory[10]=0x1234, [12]=0x5678, [14]=0x9ABC, pulse Start -> successive edges give IFID_PC/IFID_Instr = 10/0x1234, 12/0x5678, 14/0x9ABC; PCAddress advances 10, 12, 14, 16; FetchCount=3 (macro on).
- Stall: Stall=1 for 3 cycles while PC=14 -> PCAddress stays 14 and IFID stays 12/0x5678 valid; release -> next edge gives 14/0x9ABC.
- Branch with simultaneous stall: BranchTaken=1, BranchTarget=0x0031, Stall=1 -> next edge PCAddress=0x0030, IFID_Valid=0; following edge IFID_PC=0x0030 valid.
- Halt: memory[0x20]=0xFFFF, fetch reaches 0x20 -> IFID_Instr=0xFFFF valid for one cycle, then IFID_Valid=0, Halted=1, PCAddress stuck at 0x20 despite BranchTaken=1; Reset clears Halted.
- Wrap: BranchTarget=0xFFFE, memory[0xFFFE]=0x0001 -> after fetch PCAddress=0x0000, IFID_PC=0xFFFE.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//   Fetch stage of the 16-bit CPU. Owns the program counter, presents it to the
//   instruction memory as PCAddress and captures the combinationally returned
//   word into the IF/ID pipeline register. Handles decode stall, branch
//   redirect from execute and a terminal halt on HALT_OPCODE.
//
//   Optional build macro: FETCH_COUNT_EN
//     defined   -> FetchCount is a live 16-bit fetched-instruction counter
//     undefined -> FetchCount is tied to zero
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int                  ADDR_W      = 16,
    parameter int                  INSTR_W     = 16,
    parameter logic [ADDR_W-1:0]   RESET_PC    = 16'h0000,
    parameter int                  PC_STEP     = 2,
    parameter logic [INSTR_W-1:0]  HALT_OPCODE = 16'hFFFF
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Start,
    input  logic                Stall,
    input  logic                BranchTaken,
    input  logic [ADDR_W-1:0]   BranchTarget,
    output logic [ADDR_W-1:0]   PCAddress,
    input  logic [INSTR_W-1:0]  Instruction,
    output logic [INSTR_W-1:0]  IFID_Instr,
    output logic [ADDR_W-1:0]   IFID_PC,
    output logic                IFID_Valid,
    output logic                Halted,
    output logic [15:0]         FetchCount
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(PC_STEP);

    state_t               state_r,      state_s;
    logic [ADDR_W-1:0]    pc_r,         pc_s;
    logic [INSTR_W-1:0]   ifid_instr_r, ifid_instr_s;
    logic [ADDR_W-1:0]    ifid_pc_r,    ifid_pc_s;
    logic                 ifid_valid_r, ifid_valid_s;
    logic                 halted_r,     halted_s;
    logic                 fetch_s;      // a normal fetch commits this cycle

    // Next-state and next-register values; every register holds by default.
    always_comb begin
        state_s      = state_r;
        pc_s         = pc_r;
        ifid_instr_s = ifid_instr_r;
        ifid_pc_s    = ifid_pc_r;
        ifid_valid_s = ifid_valid_r;
        halted_s     = halted_r;
        fetch_s      = 1'b0;

        case (state_r)
            ST_IDLE: begin
                // Stall and BranchTaken have no effect before fetching starts.
                if (Start) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_RUN: begin
                if (BranchTaken) begin
                    // Redirect beats stall; target is forced to a word boundary.
                    pc_s         = {BranchTarget[ADDR_W-1:1], 1'b0};
                    ifid_instr_s = {INSTR_W{1'b0}};
                    ifid_pc_s    = {ADDR_W{1'b0}};
                    ifid_valid_s = 1'b0;
                end else if (Stall) begin
                    state_s = ST_RUN;
                end else begin
                    fetch_s      = 1'b1;
                    ifid_instr_s = Instruction;
                    ifid_pc_s    = pc_r;
                    ifid_valid_s = 1'b1;
                    if (Instruction == HALT_OPCODE) begin
                        // Halt word is delivered; PC parks on it.
                        state_s  = ST_HALT;
                        halted_s = 1'b1;
                    end else begin
                        pc_s = pc_r + PC_INC;
                    end
                end
            end

            ST_HALT: begin
                // Terminal until reset; only the valid flag drops.
                halted_s     = 1'b1;
                ifid_valid_s = 1'b0;
            end

            default: begin
                // Unreachable encoding: fall back to a quiet idle.
                state_s      = ST_IDLE;
                ifid_valid_s = 1'b0;
                halted_s     = 1'b0;
            end
        endcase
    end

    // State and pipeline register update with synchronous reset priority.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r      <= ST_IDLE;
            pc_r         <= RESET_PC;
            ifid_instr_r <= {INSTR_W{1'b0}};
            ifid_pc_r    <= {ADDR_W{1'b0}};
            ifid_valid_r <= 1'b0;
            halted_r     <= 1'b0;
        end else begin
            state_r      <= state_s;
            pc_r         <= pc_s;
            ifid_instr_r <= ifid_instr_s;
            ifid_pc_r    <= ifid_pc_s;
            ifid_valid_r <= ifid_valid_s;
            halted_r     <= halted_s;
        end
    end

`ifdef FETCH_COUNT_EN
    logic [15:0] fetch_count_r;

    // Fetched-instruction counter: advances only on committed normal fetches.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            fetch_count_r <= 16'h0000;
        end else if (fetch_s) begin
            fetch_count_r <= fetch_count_r + 16'h0001;
        end else begin
            fetch_count_r <= fetch_count_r;
        end
    end

    assign FetchCount = fetch_count_r;
`else
    logic unused_fetch_s;
    assign unused_fetch_s = fetch_s;
    assign FetchCount     = 16'h0000;
`endif

    assign PCAddress  = pc_r;
    assign IFID_Instr = ifid_instr_r;
    assign IFID_PC    = ifid_pc_r;
    assign IFID_Valid = ifid_valid_r;
    assign Halted     = halted_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//   Table-driven bench for instr_fetch_unit with RESET_PC = 10. Each row gives
//   the inputs applied before a rising edge and the outputs expected after it.
//   Expected rows are queued as stimulus is driven and popped after the edge.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic [15:0] pc_address;
    logic [15:0] instruction;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc;
    logic        ifid_valid;
    logic        halted;
    logic [15:0] fetch_count;

    logic [15:0] mem [0:65535];

`ifdef FETCH_COUNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    typedef struct {
        logic        rst;
        logic        st;
        logic        stl;
        logic        br;
        logic [15:0] tgt;
        logic [15:0] e_pc;
        logic [15:0] e_instr;
        logic [15:0] e_ifpc;
        logic        e_valid;
        logic        e_halt;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int row      = 0;

    instr_fetch_unit #(
        .ADDR_W      (16),
        .INSTR_W     (16),
        .RESET_PC    (16'd10),
        .PC_STEP     (2),
        .HALT_OPCODE (16'hFFFF)
    ) dut (
        .Clk          (clk),
        .Reset        (reset),
        .Start        (start),
        .Stall        (stall),
        .BranchTaken  (branch_taken),
        .BranchTarget (branch_target),
        .PCAddress    (pc_address),
        .Instruction  (instruction),
        .IFID_Instr   (ifid_instr),
        .IFID_PC      (ifid_pc),
        .IFID_Valid   (ifid_valid),
        .Halted       (halted),
        .FetchCount   (fetch_count)
    );

    // Combinational instruction memory.
    assign instruction = mem[pc_address];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic s, input logic t,
                                input logic b, input logic [15:0] tg,
                                input logic [15:0] pc, input logic [15:0] ins,
                                input logic [15:0] ipc, input logic v,
                                input logic h, input logic [15:0] c);
        vec_t x;
        x.rst = r; x.st = s; x.stl = t; x.br = b; x.tgt = tg;
        x.e_pc = pc; x.e_instr = ins; x.e_ifpc = ipc;
        x.e_valid = v; x.e_halt = h; x.e_cnt = c;
        return x;
    endfunction

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL row %0d %s: got %h expected %h", row, name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        vec_t e;
        @(negedge clk);
        reset         = v.rst;
        start         = v.st;
        stall         = v.stl;
        branch_taken  = v.br;
        branch_target = v.tgt;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL row %0d scoreboard: got empty queue expected entry", row);
        end else begin
            e = exp_q.pop_front();
            check("PCAddress",  pc_address, e.e_pc);
            check("IFID_Instr", ifid_instr, e.e_instr);
            check("IFID_PC",    ifid_pc,    e.e_ifpc);
            check("IFID_Valid", {15'd0, ifid_valid}, {15'd0, e.e_valid});
            check("Halted",     {15'd0, halted},     {15'd0, e.e_halt});
            check("FetchCount", fetch_count, CNT_ON ? e.e_cnt : 16'h0000);
        end
        row++;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        mem[16'd10]   = 16'h1234;
        mem[16'd12]   = 16'h5678;
        mem[16'd14]   = 16'h9ABC;
        mem[16'd16]   = 16'h1111;
        mem[16'h0030] = 16'h2222;
        mem[16'h0020] = 16'hFFFF;
        mem[16'hFFFE] = 16'h0001;
        mem[16'h0000] = 16'h4444;

        reset = 1'b1; start = 1'b0; stall = 1'b0;
        branch_taken = 1'b0; branch_target = 16'h0000;

        //              rst   st    stl   br    tgt       pc        instr     ifpc      v     h     cnt
        // reset, then idle (stall/branch ignored)
        tbl.push_back(mk(1'b1,1'b0,1'b0,1'b0,16'h0000,16'd10,  16'h0000,16'h0000,1'b0,1'b0,16'd0));
        tbl.push_back(mk(1'b1,1'b0,1'b0,1'b0,16'h0000,16'd10,  16'h0000,16'h0000,1'b0,1'b0,16'd0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,16'h0000,16'd10,  16'h0000,16'h0000,1'b0,1'b0,16'd0));
        tbl.push_back(mk(1'b0,1'b0,1'b1,1'b0,16'h0000,16'd10,  16'h0000,16'h0000,1'b0,1'b0,16'd0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1,16'h0040,16'd10,  16'h0000,16'h0000,1'b0,1'b0,16'd0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,16'h0000,16'd10,  16'h0000,16'h0000,1'b0,1'b0,16'd0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,16'h0000,16'd10,  16'h0000,16'h0000,1'b0,1'b0,16'd0));
        // start: enter RUN, no capture yet
        tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,16'h0000,16'd10,  16'h0000,16'h0000,1'b0,1'b0,16'd0));
        // sequential fetch
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,16'h0000,16'd12,  16'h1234,16'd10,  1'b1,1'b0,16'd1));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,16'h0000,16'd14,  16'h5678,16'd12,  1'b1,1'b0,16'd2));
        // stall x3 at PC=14
        tbl.push_back(mk(1'b0,1'b0,1'b1,1'b0,16'h0000,16'd14,  16'h5678,16'd12,  1'b1,1'b0,16'd2));
        tbl.push_back(mk(1'b0,1'b0,1'b1,1'b0,16'h0000,16'd14,  16'h5678,16'd12,  1'b1,1'b0,16'd2));
        tbl.push_back(mk(1'b0,1'b0,1'b1,1'b0,16'h0000,16'd14,  16'h5678,16'd12,  1'b1,1'b0,16'd2));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,16'h0000,16'd16,  16'h9ABC,16'd14,  1'b1,1'b0,16'd3));
        // branch with simultaneous stall, odd target forced even
        tbl.push_back(mk(1'b0,1'b0,1'b1,1'b1,16'h0031,16'h0030,16'h0000,16'h0000,1'b0,1'b0,16'd3));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0032,16'h2222,16'h0030,1'b1,1'b0,16'd4));
        // wrap at top of address space
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1,16'hFFFE,16'hFFFE,16'h0000,16'h0000,1'b0,1'b0,16'd4));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000,16'h0001,16'hFFFE,1'b1,1'b0,16'd5));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0002,16'h4444,16'h0000,1'b1,1'b0,16'd6));
        // halt at 0x20
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1,16'h0020,16'h0020,16'h0000,16'h0000,1'b0,1'b0,16'd6));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0020,16'hFFFF,16'h0020,1'b1,1'b1,16'd7));
        tbl.push_back(mk(1'b0,1'b1,1'b0,1'b1,16'h0040,16'h0020,16'hFFFF,16'h0020,1'b0,1'b1,16'd7));
        tbl.push_back(mk(1'b0,1'b0,1'b1,1'b0,16'h0000,16'h0020,16'hFFFF,16'h0020,1'b0,1'b1,16'd7));
        // reset exits halt
        tbl.push_back(mk(1'b1,1'b0,1'b0,1'b0,16'h0000,16'd10,  16'h0000,16'h0000,1'b0,1'b0,16'd0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,16'h0000,16'd10,  16'h0000,16'h0000,1'b0,1'b0,16'd0));

        foreach (tbl[i]) apply(tbl[i]);

        // Reset landing mid-stall.
        apply(mk(1'b0,1'b1,1'b0,1'b0,16'h0000,16'd10,16'h0000,16'h0000,1'b0,1'b0,16'd0));
        apply(mk(1'b0,1'b0,1'b0,1'b0,16'h0000,16'd12,16'h1234,16'd10,  1'b1,1'b0,16'd1));
        apply(mk(1'b1,1'b0,1'b1,1'b0,16'h0000,16'd10,16'h0000,16'h0000,1'b0,1'b0,16'd0));

        // Reset landing mid-branch, then confirm the unit is back in IDLE.
        apply(mk(1'b0,1'b1,1'b0,1'b0,16'h0000,16'd10,16'h0000,16'h0000,1'b0,1'b0,16'd0));
        apply(mk(1'b0,1'b0,1'b0,1'b0,16'h0000,16'd12,16'h1234,16'd10,  1'b1,1'b0,16'd1));
        apply(mk(1'b1,1'b0,1'b0,1'b1,16'h0040,16'd10,16'h0000,16'h0000,1'b0,1'b0,16'd0));
        apply(mk(1'b0,1'b0,1'b0,1'b0,16'h0000,16'd10,16'h0000,16'h0000,1'b0,1'b0,16'd0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
